piso_sched: RTL and testbench

PISO_SCHED -- requirements
Module: piso_sched

---
 rtl/piso_sched_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/piso_sched.sv | 133 +++++++++++++
 tb/tb_piso_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/piso_sched_pkg.sv
// Shared definitions for the result scheduler: FSM encoding, default sizes
// and a small wrap helper used by the round-robin search.
package piso_sched_pkg;

    // Width of one result word / one serial frame in bits.
    localparam int PISO_W_DEFAULT    = 75;
    // Number of result requesters.
    localparam int PISO_NREQ_DEFAULT = 4;

    // The FSM has exactly two states: waiting for work, or owning a frame.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } piso_state_e;

    // Fold v into 0..n-1, assuming v < 2*n.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: searches req starting one past last_grant and
// wrapping, returns the first hit as a one-hot grant plus its index.
module rr_arbiter
    import piso_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);

    logic [IW-1:0] cand_s;
    logic          hit_s;

    // Rotating priority search; the first requester found after last_grant wins.
    always_comb begin
        grant  = {N{1'b0}};
        index  = {IW{1'b0}};
        any    = 1'b0;
        cand_s = {IW{1'b0}};
        hit_s  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand_s        = IW'(rr_wrap(int'(last_grant) + i, N));
            hit_s         = !any && req[cand_s];
            grant[cand_s] = grant[cand_s] | hit_s;
            index         = hit_s ? cand_s : index;
            any           = any | hit_s;
        end
    end

endmodule

// File: rtl/piso_sched.sv
// Result scheduler: picks one ready requester round-robin, latches its word
// for a serializer and drives the shift enable for exactly W shifting cycles
// per frame. A downstream hold freezes the frame; frames chain back-to-back.
module piso_sched
    import piso_sched_pkg::*;
#(
    parameter  int N_REQ = PISO_NREQ_DEFAULT,
    parameter  int W     = PISO_W_DEFAULT,
    localparam int SW    = $clog2(N_REQ),
    localparam int CW    = $clog2(W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               hold,
    output logic [W-1:0]       piso_din,
    output logic               piso_en,
    output logic [SW-1:0]      src,
    output logic               frame_last,
    output logic               busy
);

    piso_state_e   state_r;
    logic [CW-1:0] bit_cnt_r;
    logic [SW-1:0] last_grant_r;
    logic [W-1:0]  piso_din_r;
    logic [SW-1:0] src_r;

    logic [N_REQ-1:0] arb_grant_s;
    logic [SW-1:0]    arb_index_s;
    logic             arb_any_s;

    logic          shifting_s;
    logic          last_bit_s;
    logic          slot_s;
    logic          fire_s;
    logic [W-1:0]  word_s;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (SW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (arb_grant_s),
        .index      (arb_index_s),
        .any        (arb_any_s)
    );

    // Grant window: IDLE or the final shifting cycle, never under hold or reset.
    always_comb begin
        shifting_s = 1'b0;
        last_bit_s = 1'b0;
        slot_s     = 1'b0;
        shifting_s = !rst && (state_r == ST_SHIFT);
        last_bit_s = shifting_s && !hold && (bit_cnt_r == {CW{1'b0}});
        if (rst || hold) begin
            slot_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            slot_s = 1'b1;
        end else begin
            slot_s = last_bit_s;
        end
        fire_s = slot_s && arb_any_s;
    end

    // Select the winning requester's word with constant part-selects.
    always_comb begin
        word_s = {W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            word_s = (arb_index_s == SW'(k)) ? req_data[k*W +: W] : word_s;
        end
    end

    // Grant pulse and shift controls follow the current cycle's decision.
    always_comb begin
        req_ready  = fire_s ? arb_grant_s : {N_REQ{1'b0}};
        piso_en    = shifting_s && !hold;
        frame_last = last_bit_s;
        busy       = shifting_s;
        piso_din   = piso_din_r;
        src        = src_r;
    end

    // FSM, bit counter and frame data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= {CW{1'b0}};
            last_grant_r <= SW'(N_REQ - 1);
            piso_din_r   <= {W{1'b0}};
            src_r        <= {SW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fire_s) begin
                        state_r      <= ST_SHIFT;
                        bit_cnt_r    <= CW'(W - 1);
                        piso_din_r   <= word_s;
                        src_r        <= arb_index_s;
                        last_grant_r <= arb_index_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (hold) begin
                        state_r <= ST_SHIFT;
                    end else if (bit_cnt_r == {CW{1'b0}}) begin
                        if (fire_s) begin
                            state_r      <= ST_SHIFT;
                            bit_cnt_r    <= CW'(W - 1);
                            piso_din_r   <= word_s;
                            src_r        <= arb_index_s;
                            last_grant_r <= arb_index_s;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r - CW'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_sched.sv
// Self-checking bench for piso_sched: a frame-level reference model (a word
// in flight plus a count of shifts still owed) checked every cycle, with
// directed scenarios for the called-out cases and a randomized soak.
module tb_piso_sched;

    localparam int N = 4;
    localparam int W = 75;
    localparam logic [W-1:0] D0 = 75'h4204016000000000001;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             hold;
    logic [W-1:0]     piso_din;
    logic             piso_en;
    logic [1:0]       src;
    logic             frame_last;
    logic             busy;

    piso_sched #(.N_REQ(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .hold       (hold),
        .piso_din   (piso_din),
        .piso_en    (piso_en),
        .src        (src),
        .frame_last (frame_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: frame in flight and shifts still owed
    bit         m_busy;
    int         m_rem;
    int         m_last;
    logic [W-1:0] m_din;
    int         m_src;
    int         grants[$];

    // observations of the most recent step
    logic [N-1:0] obs_ready;
    logic         obs_en, obs_last, obs_busy;
    logic [W-1:0] obs_din;
    logic [1:0]   obs_src;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic timeout(input string tag);
        n_fail++;
        $display("FAIL timeout %s (t=%0t)", tag, $time);
    endtask

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] r;
        logic [95:0]    t;
        for (int k = 0; k < N; k++) begin
            t = {$urandom, $urandom, $urandom};
            r[k*W +: W] = t[W-1:0];
        end
        return r;
    endfunction

    // One clock cycle: drive inputs, check against the model, advance the model.
    task automatic step(input logic [N-1:0] v, input logic h, input logic r, input logic [N*W-1:0] d);
        logic [N-1:0] er;
        int  win;
        bit  slot;
        req_valid = v;
        hold      = h;
        rst       = r;
        req_data  = d;
        #1;
        win  = -1;
        er   = '0;
        slot = !r && !h && (!m_busy || m_rem == 1);
        if (slot) begin
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (m_last + i) % N;
                if (win < 0 && v[c]) win = c;
            end
        end
        if (win >= 0) er[win] = 1'b1;
        check("req_ready",  req_ready,  er);
        check("piso_en",    piso_en,    !r && m_busy && !h);
        check("frame_last", frame_last, !r && m_busy && !h && m_rem == 1);
        check("busy",       busy,       !r && m_busy);
        check("piso_din",   piso_din,   m_din);
        check("src",        src,        m_src);
        obs_ready = req_ready;
        obs_en    = piso_en;
        obs_last  = frame_last;
        obs_busy  = busy;
        obs_din   = piso_din;
        obs_src   = src;
        if (r) begin
            m_busy = 0; m_rem = 0; m_last = N - 1; m_din = '0; m_src = 0;
        end else begin
            if (m_busy && !h) begin
                m_rem--;
                if (m_rem == 0) m_busy = 0;
            end
            if (win >= 0) begin
                m_busy = 1; m_rem = W; m_din = d[win*W +: W]; m_src = win; m_last = win;
                grants.push_back(win);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [N*W-1:0] dp;
        int cnt, last_at, steps, en_cnt, held, last_t;
        bit hold_en_seen, done;
        logic [3:0] v;

        rst = 1'b1; hold = 1'b0; req_valid = '0; req_data = '0;
        m_busy = 0; m_rem = 0; m_last = N - 1; m_din = '0; m_src = 0;
        repeat (2) @(negedge clk);

        // reset state, then single request from requester 0
        step(4'b0000, 1'b0, 1'b1, rand_data());
        dp = rand_data();
        dp[W-1:0] = D0;
        step(4'b0001, 1'b0, 1'b0, dp);
        check("first_grant", obs_ready, 4'b0001);
        cnt = 0; last_at = 0;
        for (int i = 0; i < 80; i++) begin
            step(4'b0000, 1'b0, 1'b0, rand_data());
            if (obs_en) cnt++;
            if (obs_last && last_at == 0) last_at = cnt;
        end
        check("frame_len", cnt, W);
        check("last_pos", last_at, W);
        check("idle_after", obs_busy, 1'b0);
        check("din_kept", obs_din, D0);
        check("src_kept", obs_src, 2'd0);

        // all requesters valid: 0,1,2,3,0 back-to-back
        step(4'b0000, 1'b0, 1'b1, rand_data());
        grants.delete();
        steps = 0; en_cnt = 0;
        for (int i = 0; i < 600 && grants.size() < 5; i++) begin
            step(4'b1111, 1'b0, 1'b0, rand_data());
            if (grants.size() > 1 || (grants.size() == 1 && i > 0)) begin
                steps++;
                if (obs_en) en_cnt++;
            end
        end
        if (grants.size() < 5) timeout("b2b");
        else begin
            check("b2b_g0", grants[0], 0);
            check("b2b_g1", grants[1], 1);
            check("b2b_g2", grants[2], 2);
            check("b2b_g3", grants[3], 3);
            check("b2b_g4", grants[4], 0);
        end
        check("b2b_en", en_cnt, 4 * W);
        check("b2b_steps", steps, 4 * W);

        // hold for 10 cycles at bit_cnt=40
        step(4'b0000, 1'b0, 1'b1, rand_data());
        step(4'b0001, 1'b0, 1'b0, rand_data());
        held = 0; last_t = 0; hold_en_seen = 0;
        for (int t = 1; t <= 120 && last_t == 0; t++) begin
            logic h;
            h = (m_rem == 41 && held < 10);
            if (h) held++;
            step(4'b0000, h, 1'b0, rand_data());
            if (h && obs_en) hold_en_seen = 1;
            if (obs_last) last_t = t;
        end
        if (last_t == 0) timeout("hold_frame");
        check("hold_cycles", held, 10);
        check("hold_en_low", hold_en_seen, 1'b0);
        check("hold_last_t", last_t, 85);

        // reset mid-frame at bit_cnt=20 with all requesters valid
        step(4'b0000, 1'b0, 1'b1, rand_data());
        step(4'b1111, 1'b0, 1'b0, rand_data());
        for (int i = 0; i < 200 && m_rem != 21; i++) step(4'b1111, 1'b0, 1'b0, rand_data());
        if (m_rem != 21) timeout("rst_mid");
        step(4'b1111, 1'b0, 1'b1, rand_data());
        check("rst_no_grant", obs_ready, 4'b0000);
        check("rst_no_last", obs_last, 1'b0);
        step(4'b1111, 1'b0, 1'b0, rand_data());
        check("post_rst_busy", obs_busy, 1'b0);
        check("post_rst_din", obs_din, '0);
        check("post_rst_src", obs_src, 2'd0);
        check("post_rst_grant", obs_ready, 4'b0001);

        // wrap after requester 2, and hold on the frame_last-candidate cycle
        step(4'b0000, 1'b0, 1'b1, rand_data());
        step(4'b0100, 1'b0, 1'b0, rand_data());
        check("grant2", obs_ready, 4'b0100);
        for (int i = 0; i < 200 && m_rem > 1; i++) step(4'b0000, 1'b0, 1'b0, rand_data());
        if (m_rem != 1) timeout("wrap");
        step(4'b0101, 1'b1, 1'b0, rand_data());
        check("hold_no_grant", obs_ready, 4'b0000);
        step(4'b0101, 1'b0, 1'b0, rand_data());
        check("wrap_grant0", obs_ready, 4'b0001);
        check("wrap_last", obs_last, 1'b1);

        // randomized soak
        step(4'b0000, 1'b0, 1'b1, rand_data());
        for (int i = 0; i < 3000; i++) begin
            v = 4'($urandom);
            if ($urandom_range(0, 3) == 0) v = 4'b0000;
            step(v, ($urandom_range(0, 4) == 0), ($urandom_range(0, 299) == 0), rand_data());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
